result_stage_pipe: RTL and testbench
====================================

Name: result_stage_pipe

Overview:
- Producer end of the packed-stage forwarding interface: takes the registered results of the even and odd execution units and shifts them through 7 result stages.
- Drives the 14 packed stage vectors consumed by register fetch/forwarding.
- Performs register-file writeback from stage 7 on write ports 1 (even) and 2 (odd).
- Masks results that have not completed their unit latency so that they are never forwarded.

Parameters:
- DEPTH, 7, number of result stages; fixed by the interface, and the ports below assume 7.
- FLUSH_DEPTH, 1, number of youngest stages (1..FLUSH_DEPTH) squashed by flush.
- CNT_W, 32, width of the writeback counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_unit_id_even  in  3  unit id of the even-unit result.
- in_result_even  in  128  result data.
- in_reg_dst_even  in  7  destination register.
- in_reg_wr_even  in  1  result writes the register file.
- in_latency_even  in  4  unit latency in cycles, 1..7.
- in_unit_id_odd / in_result_odd / in_reg_dst_odd / in_reg_wr_odd / in_latency_odd  in  3/128/7/1/4  same fields for the odd pipe.
- flush  in  1  branch squash of the youngest FLUSH_DEPTH stages, both pipes.
- packed_1stage_even .. packed_7stage_even  out  143 each  stage k even entry.
- packed_1stage_odd .. packed_7stage_odd  out  143 each  stage k odd entry.
- reg_write_en_1 / reg_write_addr_1 / reg_write_data_1  out  1/7/128  even writeback.
- reg_write_en_2 / reg_write_addr_2 / reg_write_data_2  out  1/7/128  odd writeback.
- wb_count_even / wb_count_odd  out  CNT_W each  committed writes per pipe.

Behaviour:
- Packed layout, MSB-first indexing [0:142]:
  - [0:2] unit_id
  - [3:130] result
  - [131:137] reg_dst
  - [138] reg_wr
  - [139:142] latency
- Each pipe has 7 stage registers: S1 <= input entry, Sk <= S(k-1), one shift per clock, no stall.
- Latency normalisation on capture: latency 0 stores reg_wr=0, i.e. an inert bubble; latency >7 is clamped to 7.
- Forward mask (combinational on outputs only): packed_kstage[138] = Sk.reg_wr AND (k >= Sk.latency). All other fields pass through unmasked, and the stored reg_wr is unchanged.
- Writeback (combinational from S7):
  - reg_write_en_1 = S7_even.reg_wr; addr = S7_even.reg_dst; data = S7_even.result.
  - Port 2 is driven the same way from S7_odd.
  - The register file commits at the next clk edge.
- Same-address conflict: if both enables are set and addr_1 == addr_2, reg_write_en_1 is forced 0. The odd instruction is younger in program order and wins.
- Flush:
  - Clears stored reg_wr in stages 1..FLUSH_DEPTH of both pipes at the edge.
  - At that same edge, the shifting-in S1 capture also gets reg_wr=0.
  - Older stages are unaffected.
- Counters: wb_count_x increments by 1 on each clk edge where that port's effective enable (after conflict suppression) is 1, and wraps modulo 2^CNT_W.
- Reset (rst low, asynchronous):
  - All stage fields are cleared to 0, so every packed output is 143'b0.
  - Both write enables, addresses and data are 0; counters are 0.
  - The first capture happens on the first clk edge after rst rises.
  - Reset mid-operation discards all in-flight results with no writeback.
- Latency: an entry captured at edge 0 appears on packed_1stage after edge 0 and on packed_kstage after edge k-1. It drives writeback during the cycle after edge 6 and commits at edge 7.
- Same reg_dst in multiple stages is legal. Priority among stages belongs to the consumer; this block never merges entries.

Decomposition:
- Shared package holds the packed field offsets (UNIT_LSB..LAT_MSB), PACKED_W=143, DATA_W=128, REG_AW=7, and the MAX_LAT=7 constant.
- One natural sub-module, result_stage_lane: the 7-stage shift, flush clear, latency normalisation and forward masking for one pipe.
- result_stage_lane is instantiated twice, for even and odd.
- The top level adds conflict suppression, writeback and the counters.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst low mid-traffic.
  - Response: all packed outputs are 0, reg_write_en_1/2 are 0 and the counters are 0, immediately and without waiting for a clk edge.
- Even entry (unit 2, result 128'hA5.., dst 12, reg_wr 1, latency 4):
  - packed_1..3stage_even[138] = 0 and packed_4..7stage_even[138] = 1.
  - Cycle after edge 6: reg_write_en_1 = 1, addr 12, data A5..
  - wb_count_even = 1 after edge 7.
- Latency 0 and latency 9 inputs:
  - Latency 0 never raises [138] or reg_write_en.
  - Latency 9 shows latency field 7 and [138] = 1 only at stage 7.
- Conflict: even and odd both dst 5, reg_wr 1, captured same edge.
  - At stage 7: reg_write_en_1 = 0, reg_write_en_2 = 1 with the odd data.
  - wb_count_odd increments and wb_count_even does not.
- Flush (FLUSH_DEPTH=1) asserted one cycle after capturing an entry:
  - The entry in S1 loses reg_wr and is never written back.
  - The entry captured on the flush edge is also squashed.
  - An entry in S2 is written back normally.
- Back-to-back stream of 10 entries with dst 0..9, latency 7:
  - Writebacks occur on 10 consecutive cycles with addresses 0..9 in order.
  - wb_count_even = 10.

Source files
------------

// File: rtl/result_stage_pipe_pkg.sv
// Shared field layout and helpers for the packed result-stage forwarding interface.
// Packed vectors use MSB-first numbering [0:142]; *_MSB is the lower index of a field.
package result_stage_pipe_pkg;

    localparam int DATA_W   = 128;
    localparam int REG_AW   = 7;
    localparam int UNIT_W   = 3;
    localparam int LAT_W    = 4;
    localparam int PACKED_W = 143;

    localparam int UNIT_MSB = 0;
    localparam int UNIT_LSB = 2;
    localparam int RES_MSB  = 3;
    localparam int RES_LSB  = 130;
    localparam int DST_MSB  = 131;
    localparam int DST_LSB  = 137;
    localparam int WR_BIT   = 138;
    localparam int LAT_MSB  = 139;
    localparam int LAT_LSB  = 142;

    localparam logic [LAT_W-1:0] MAX_LAT = 4'd7;

    typedef logic [0:PACKED_W-1] packed_t;

    // Member order matches the packed layout, so a struct casts straight onto packed_t.
    typedef struct packed {
        logic [UNIT_W-1:0] unit_id;
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] reg_dst;
        logic              reg_wr;
        logic [LAT_W-1:0]  latency;
    } stage_entry_t;

    function automatic logic [LAT_W-1:0] clamp_latency(input logic [LAT_W-1:0] lat);
        return (lat > MAX_LAT) ? MAX_LAT : lat;
    endfunction

    function automatic packed_t pack_entry(input stage_entry_t e, input logic fwd);
        packed_t p;
        p         = e;
        p[WR_BIT] = fwd;
        return p;
    endfunction

endpackage

// File: rtl/result_stage_pipe_lane.sv
// One pipe of result stages: capture with latency normalisation, shift, flush squash,
// and forward masking of results that have not yet completed their unit latency.
module result_stage_lane
    import result_stage_pipe_pkg::*;
#(
    parameter int DEPTH       = 7,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UNIT_W-1:0] unit_id,
    input  logic [DATA_W-1:0] result,
    input  logic [REG_AW-1:0] reg_dst,
    input  logic              reg_wr,
    input  logic [LAT_W-1:0]  latency,
    input  logic              flush,
    output packed_t           packed_stage [1:DEPTH],
    output logic              wb_wr,
    output logic [REG_AW-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_data
);

    stage_entry_t stage_q [1:DEPTH];
    stage_entry_t capture;

    // NOTE: always_comb assigns every field on every pass so no latch is inferred.
    always_comb begin
        capture.unit_id = unit_id;
        capture.result  = result;
        capture.reg_dst = reg_dst;
        capture.latency = clamp_latency(latency);
        capture.reg_wr  = reg_wr && (latency != '0) && !flush;
    end

    // NOTE: stage registers are reset so that an aborted pipe can never write back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            stage_q[1] <= capture;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
                if (flush && (k - 1) <= FLUSH_DEPTH) begin
                    stage_q[k].reg_wr <= 1'b0;
                end
            end
        end
    end

    // Stored reg_wr stays intact; only the forwarded copy is gated by stage age.
    for (genvar k = 1; k <= DEPTH; k++) begin : g_mask
        assign packed_stage[k] = pack_entry(stage_q[k],
                                            stage_q[k].reg_wr && (LAT_W'(k) >= stage_q[k].latency));
    end

    assign wb_wr   = stage_q[DEPTH].reg_wr;
    assign wb_dst  = stage_q[DEPTH].reg_dst;
    assign wb_data = stage_q[DEPTH].result;

endmodule

// File: rtl/result_stage_pipe.sv
// Even/odd result-stage pipes feeding forwarding, with stage-7 register-file writeback,
// same-address conflict resolution (odd wins) and committed-write counters.
module result_stage_pipe
    import result_stage_pipe_pkg::*;
#(
    parameter int DEPTH       = 7,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [UNIT_W-1:0]   in_unit_id_even,
    input  logic [DATA_W-1:0]   in_result_even,
    input  logic [REG_AW-1:0]   in_reg_dst_even,
    input  logic                in_reg_wr_even,
    input  logic [LAT_W-1:0]    in_latency_even,
    input  logic [UNIT_W-1:0]   in_unit_id_odd,
    input  logic [DATA_W-1:0]   in_result_odd,
    input  logic [REG_AW-1:0]   in_reg_dst_odd,
    input  logic                in_reg_wr_odd,
    input  logic [LAT_W-1:0]    in_latency_odd,
    input  logic                flush,
    output logic [0:PACKED_W-1] packed_1stage_even,
    output logic [0:PACKED_W-1] packed_2stage_even,
    output logic [0:PACKED_W-1] packed_3stage_even,
    output logic [0:PACKED_W-1] packed_4stage_even,
    output logic [0:PACKED_W-1] packed_5stage_even,
    output logic [0:PACKED_W-1] packed_6stage_even,
    output logic [0:PACKED_W-1] packed_7stage_even,
    output logic [0:PACKED_W-1] packed_1stage_odd,
    output logic [0:PACKED_W-1] packed_2stage_odd,
    output logic [0:PACKED_W-1] packed_3stage_odd,
    output logic [0:PACKED_W-1] packed_4stage_odd,
    output logic [0:PACKED_W-1] packed_5stage_odd,
    output logic [0:PACKED_W-1] packed_6stage_odd,
    output logic [0:PACKED_W-1] packed_7stage_odd,
    output logic                reg_write_en_1,
    output logic [REG_AW-1:0]   reg_write_addr_1,
    output logic [DATA_W-1:0]   reg_write_data_1,
    output logic                reg_write_en_2,
    output logic [REG_AW-1:0]   reg_write_addr_2,
    output logic [DATA_W-1:0]   reg_write_data_2,
    output logic [CNT_W-1:0]    wb_count_even,
    output logic [CNT_W-1:0]    wb_count_odd
);

    packed_t           stage_even [1:DEPTH];
    packed_t           stage_odd  [1:DEPTH];
    logic              wb_wr_even, wb_wr_odd;
    logic [REG_AW-1:0] wb_dst_even, wb_dst_odd;

    result_stage_lane #(.DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH)) u_lane_even (
        .clk          (clk),
        .rst          (rst),
        .unit_id      (in_unit_id_even),
        .result       (in_result_even),
        .reg_dst      (in_reg_dst_even),
        .reg_wr       (in_reg_wr_even),
        .latency      (in_latency_even),
        .flush        (flush),
        .packed_stage (stage_even),
        .wb_wr        (wb_wr_even),
        .wb_dst       (wb_dst_even),
        .wb_data      (reg_write_data_1)
    );

    result_stage_lane #(.DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH)) u_lane_odd (
        .clk          (clk),
        .rst          (rst),
        .unit_id      (in_unit_id_odd),
        .result       (in_result_odd),
        .reg_dst      (in_reg_dst_odd),
        .reg_wr       (in_reg_wr_odd),
        .latency      (in_latency_odd),
        .flush        (flush),
        .packed_stage (stage_odd),
        .wb_wr        (wb_wr_odd),
        .wb_dst       (wb_dst_odd),
        .wb_data      (reg_write_data_2)
    );

    assign packed_1stage_even = stage_even[1];
    assign packed_2stage_even = stage_even[2];
    assign packed_3stage_even = stage_even[3];
    assign packed_4stage_even = stage_even[4];
    assign packed_5stage_even = stage_even[5];
    assign packed_6stage_even = stage_even[6];
    assign packed_7stage_even = stage_even[7];
    assign packed_1stage_odd  = stage_odd[1];
    assign packed_2stage_odd  = stage_odd[2];
    assign packed_3stage_odd  = stage_odd[3];
    assign packed_4stage_odd  = stage_odd[4];
    assign packed_5stage_odd  = stage_odd[5];
    assign packed_6stage_odd  = stage_odd[6];
    assign packed_7stage_odd  = stage_odd[7];

    // The odd instruction is younger in program order, so it owns a shared destination.
    assign reg_write_en_2   = wb_wr_odd;
    assign reg_write_en_1   = wb_wr_even && !(wb_wr_odd && (wb_dst_even == wb_dst_odd));
    assign reg_write_addr_1 = wb_dst_even;
    assign reg_write_addr_2 = wb_dst_odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_even <= '0;
            wb_count_odd  <= '0;
        end else begin
            if (reg_write_en_1) wb_count_even <= wb_count_even + CNT_W'(1);
            if (reg_write_en_2) wb_count_odd  <= wb_count_odd + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_result_stage_pipe.sv
// Directed bench for result_stage_pipe: latency table, flush, conflict, reset and streaming.
module tb_result_stage_pipe;
    import result_stage_pipe_pkg::*;

    logic               clk;
    logic               rst;
    logic [2:0]         u_e, u_o;
    logic [127:0]       r_e, r_o;
    logic [6:0]         d_e, d_o;
    logic               w_e, w_o;
    logic [3:0]         l_e, l_o;
    logic               flush;
    logic [0:142]       p1e, p2e, p3e, p4e, p5e, p6e, p7e;
    logic [0:142]       p1o, p2o, p3o, p4o, p5o, p6o, p7o;
    logic               en1, en2;
    logic [6:0]         addr1, addr2;
    logic [127:0]       data1, data2;
    logic [31:0]        cnt_e, cnt_o;
    logic [0:142]       pe [1:7];
    logic [0:142]       po [1:7];

    int checks = 0;
    int errors = 0;
    int exp_cnt_e = 0;
    int exp_cnt_o = 0;

    result_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_unit_id_even(u_e), .in_result_even(r_e), .in_reg_dst_even(d_e),
        .in_reg_wr_even(w_e), .in_latency_even(l_e),
        .in_unit_id_odd(u_o), .in_result_odd(r_o), .in_reg_dst_odd(d_o),
        .in_reg_wr_odd(w_o), .in_latency_odd(l_o),
        .flush(flush),
        .packed_1stage_even(p1e), .packed_2stage_even(p2e), .packed_3stage_even(p3e),
        .packed_4stage_even(p4e), .packed_5stage_even(p5e), .packed_6stage_even(p6e),
        .packed_7stage_even(p7e),
        .packed_1stage_odd(p1o), .packed_2stage_odd(p2o), .packed_3stage_odd(p3o),
        .packed_4stage_odd(p4o), .packed_5stage_odd(p5o), .packed_6stage_odd(p6o),
        .packed_7stage_odd(p7o),
        .reg_write_en_1(en1), .reg_write_addr_1(addr1), .reg_write_data_1(data1),
        .reg_write_en_2(en2), .reg_write_addr_2(addr2), .reg_write_data_2(data2),
        .wb_count_even(cnt_e), .wb_count_odd(cnt_o)
    );

    assign pe[1] = p1e; assign pe[2] = p2e; assign pe[3] = p3e; assign pe[4] = p4e;
    assign pe[5] = p5e; assign pe[6] = p6e; assign pe[7] = p7e;
    assign po[1] = p1o; assign po[2] = p2o; assign po[3] = p3o; assign po[4] = p4o;
    assign po[5] = p5o; assign po[6] = p6o; assign po[7] = p7o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [142:0] act, input logic [142:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        u_e = '0; r_e = '0; d_e = '0; w_e = 1'b0; l_e = '0;
        u_o = '0; r_o = '0; d_o = '0; w_o = 1'b0; l_o = '0;
        flush = 1'b0;
    endtask

    task automatic drive_even(input logic [2:0] u, input logic [127:0] r, input logic [6:0] d,
                              input logic w, input logic [3:0] l);
        u_e = u; r_e = r; d_e = d; w_e = w; l_e = l;
    endtask

    task automatic drive_odd(input logic [2:0] u, input logic [127:0] r, input logic [6:0] d,
                             input logic w, input logic [3:0] l);
        u_o = u; r_o = r; d_o = d; w_o = w; l_o = l;
    endtask

    task automatic check_all_zero(input string tag);
        logic any_bit;
        any_bit = 1'b0;
        for (int k = 1; k <= 7; k++) any_bit = any_bit | (|pe[k]) | (|po[k]);
        check({tag, "_packed"}, any_bit, 1'b0);
        check({tag, "_wb_ctl"}, {en1, en2, addr1, addr2}, '0);
        check({tag, "_wb_data"}, data1 | data2, '0);
        check({tag, "_cnt_e"}, cnt_e, '0);
        check({tag, "_cnt_o"}, cnt_o, '0);
    endtask

    typedef struct {
        logic [3:0] lat;
        logic       wr;
        logic [6:0] dst;
        logic [3:0] exp_lat;
        logic [7:1] exp_mask;
        logic       exp_wb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [127:0] res;
        logic [0:142] exp_p;
        logic [127:0] e_data, o_data;

        vecs[0] = '{lat: 4'd4,  wr: 1'b1, dst: 7'd12, exp_lat: 4'd4, exp_mask: 7'b1111000, exp_wb: 1'b1};
        vecs[1] = '{lat: 4'd0,  wr: 1'b1, dst: 7'd13, exp_lat: 4'd0, exp_mask: 7'b0000000, exp_wb: 1'b0};
        vecs[2] = '{lat: 4'd9,  wr: 1'b1, dst: 7'd14, exp_lat: 4'd7, exp_mask: 7'b1000000, exp_wb: 1'b1};
        vecs[3] = '{lat: 4'd1,  wr: 1'b1, dst: 7'd15, exp_lat: 4'd1, exp_mask: 7'b1111111, exp_wb: 1'b1};
        vecs[4] = '{lat: 4'd7,  wr: 1'b1, dst: 7'd16, exp_lat: 4'd7, exp_mask: 7'b1000000, exp_wb: 1'b1};
        vecs[5] = '{lat: 4'd15, wr: 1'b1, dst: 7'd17, exp_lat: 4'd7, exp_mask: 7'b1000000, exp_wb: 1'b1};
        vecs[6] = '{lat: 4'd3,  wr: 1'b0, dst: 7'd18, exp_lat: 4'd3, exp_mask: 7'b0000000, exp_wb: 1'b0};
        vecs[7] = '{lat: 4'd5,  wr: 1'b1, dst: 7'd127, exp_lat: 4'd5, exp_mask: 7'b1110000, exp_wb: 1'b1};

        // Power-on reset.
        idle();
        rst = 1'b0;
        #1;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Latency/mask table on the even pipe, one entry at a time.
        for (int i = 0; i < 8; i++) begin
            res = {16{8'hA5}} ^ 128'(i);
            drive_even(3'd2, res, vecs[i].dst, vecs[i].wr, vecs[i].lat);
            step();
            idle();
            for (int k = 1; k <= 7; k++) begin
                exp_p = {3'd2, res, vecs[i].dst, vecs[i].exp_mask[k], vecs[i].exp_lat};
                check($sformatf("v%0d_stage%0d", i, k), pe[k], exp_p);
                if (k < 7) step();
            end
            check($sformatf("v%0d_wb_en1", i), en1, vecs[i].exp_wb);
            if (vecs[i].exp_wb) begin
                check($sformatf("v%0d_wb_addr1", i), addr1, vecs[i].dst);
                check($sformatf("v%0d_wb_data1", i), data1, res);
            end
            step();
            if (vecs[i].exp_wb) exp_cnt_e++;
            check($sformatf("v%0d_cnt_e", i), cnt_e, exp_cnt_e);
            check($sformatf("v%0d_en1_after", i), en1, 1'b0);
        end

        // Flush: X older (in S2 at flush edge), A in S1, B captured on the flush edge.
        drive_even(3'd1, 128'h1111, 7'd30, 1'b1, 4'd1);
        step();
        drive_even(3'd1, 128'h2222, 7'd31, 1'b1, 4'd1);
        step();
        drive_even(3'd1, 128'h3333, 7'd32, 1'b1, 4'd1);
        flush = 1'b1;
        step();
        idle();
        check("flush_s1_wr", pe[1][138], 1'b0);
        check("flush_s2_wr", pe[2][138], 1'b0);
        check("flush_s3_wr", pe[3][138], 1'b1);
        check("flush_s3_dst", pe[3][131:137], 7'd30);
        repeat (4) step();
        check("flush_x_en1", en1, 1'b1);
        check("flush_x_addr1", addr1, 7'd30);
        step();
        exp_cnt_e++;
        check("flush_cnt_e", cnt_e, exp_cnt_e);
        check("flush_a_en1", en1, 1'b0);
        step();
        check("flush_b_en1", en1, 1'b0);
        step();
        check("flush_cnt_e_final", cnt_e, exp_cnt_e);

        // Same-destination conflict: odd wins.
        e_data = {4{32'hE0E0_0001}};
        o_data = {4{32'h0D0D_0002}};
        drive_even(3'd1, e_data, 7'd5, 1'b1, 4'd3);
        drive_odd(3'd4, o_data, 7'd5, 1'b1, 4'd3);
        step();
        idle();
        repeat (6) step();
        check("conf_en1", en1, 1'b0);
        check("conf_en2", en2, 1'b1);
        check("conf_addr2", addr2, 7'd5);
        check("conf_data2", data2, o_data);
        check("conf_odd_s7", po[7], {3'd4, o_data, 7'd5, 1'b1, 4'd3});
        step();
        exp_cnt_o++;
        check("conf_cnt_e", cnt_e, exp_cnt_e);
        check("conf_cnt_o", cnt_o, exp_cnt_o);

        // Different destinations: both ports write.
        drive_even(3'd1, e_data, 7'd5, 1'b1, 4'd2);
        drive_odd(3'd4, o_data, 7'd6, 1'b1, 4'd2);
        step();
        idle();
        repeat (6) step();
        check("noconf_en", {en1, en2}, 2'b11);
        check("noconf_addr", {addr1, addr2}, {7'd5, 7'd6});
        check("noconf_data1", data1, e_data);
        step();
        exp_cnt_e++;
        exp_cnt_o++;
        check("noconf_cnt_e", cnt_e, exp_cnt_e);
        check("noconf_cnt_o", cnt_o, exp_cnt_o);

        // Asynchronous reset mid-traffic discards everything in flight.
        for (int i = 0; i < 3; i++) begin
            drive_even(3'd3, 128'(i + 100), 7'(40 + i), 1'b1, 4'd2);
            drive_odd(3'd3, 128'(i + 200), 7'(50 + i), 1'b1, 4'd2);
            step();
        end
        idle();
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        check_all_zero("midrst_hold");
        #2;
        rst = 1'b1;
        exp_cnt_e = 0;
        exp_cnt_o = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("postrst_en_c%0d", c), {en1, en2}, 2'b00);
        end
        check("postrst_cnt_e", cnt_e, 0);
        check("postrst_cnt_o", cnt_o, 0);

        // Back-to-back stream of 10 entries, latency 7.
        for (int c = 0; c <= 16; c++) begin
            if (c < 10) drive_even(3'd5, {16{8'h5A}} ^ 128'(c), 7'(c), 1'b1, 4'd7);
            else        idle();
            step();
            if (c >= 6 && c <= 15) begin
                check($sformatf("stream_en1_c%0d", c), en1, 1'b1);
                check($sformatf("stream_addr1_c%0d", c), addr1, 7'(c - 6));
                check($sformatf("stream_data1_c%0d", c), data1, {16{8'h5A}} ^ 128'(c - 6));
            end
        end
        check("stream_en1_end", en1, 1'b0);
        check("stream_cnt_e", cnt_e, 10);
        check("stream_cnt_o", cnt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
